dm_port_arbiter: RTL and testbench
==================================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single data-memory port (dm) between the pipelined CPU's MEM stage and a
//  word-burst DMA engine (debug loader / peripheral copy). CPU has priority; a saturating
//  starvation counter forces a DMA beat after STARVE_LIMIT waiting cycles, stalling the CPU
//  for exactly that cycle. Sits between sccpu/dma master and dm inside the top level.
// PARAMETERS
//  STARVE_LIMIT  4        cycles a pending DMA beat waits before a forced grant (>=1)
//  MAX_LEN       16       max words per DMA burst
//  DMA_WR_CODE   2'b11    MemWrite code driven for a DMA word store
//  DMA_RD_CODE   3'b011   MemRead code driven for a DMA word load
// PORTS
//  clk           in   1   clock; all state on rising edge
//  rst           in   1   asynchronous reset, active high
//  cpu_memwrite  in   2   CPU MemWrite code (0 = no store)
//  cpu_memread   in   3   CPU MemRead code (0 = no load)
//  cpu_addr      in   32  CPU byte address
//  cpu_wdata     in   32  CPU store data
//  cpu_rdata     out  32  dm_rdata passed through to CPU
//  cpu_stall     out  1   CPU must hold MEM stage this cycle
//  dma_start     in   1   pulse: begin burst (ignored while dma_busy)
//  dma_we        in   1   burst direction, 1 = write memory; sampled at dma_start
//  dma_addr      in   32  burst base byte address, word aligned; sampled at dma_start
//  dma_len       in   5   words in burst, 1..MAX_LEN; 0 or >MAX_LEN treated as MAX_LEN
//  dma_wdata     in   32  write word for current beat, held until dma_wack
//  dma_wack      out  1   write beat committed this cycle (next word may be presented)
//  dma_rdata     out  32  registered read word
//  dma_rvalid    out  1   one-cycle pulse, dma_rdata valid
//  dma_busy      out  1   burst in progress
//  dma_done      out  1   one-cycle pulse after last beat
//  dm_memwrite   out  2   to dm MemWrite
//  dm_memread    out  3   to dm MemRead
//  dm_addr       out  32  to dm addr
//  dm_wdata      out  32  to dm din
//  dm_rdata      in   32  from dm dout (combinational read)
// BEHAVIOUR
//  - Reset: state IDLE, wait_cnt=0, beat_cnt=0, dma_rvalid/dma_done/dma_busy=0, dma_rdata=0;
//    while rst=1, dm_memwrite=0 and dm_memread=0 (no memory write at any edge in reset).
//  - FSM IDLE -> BURST on dma_start (latch base addr, len, we; cur_addr=base, beat_cnt=len).
//    BURST -> DONE when last beat granted; DONE -> IDLE next cycle with dma_done=1 in DONE.
//  - cpu_act = |cpu_memwrite | |cpu_memread (combinational).
//  - Beat grant (comb.): gnt = (state==BURST) && (!cpu_act || wait_cnt>=STARVE_LIMIT).
//  - gnt=1: dm driven with DMA codes, cur_addr, dma_wdata; cpu_stall=cpu_act. gnt=0: dm ports
//    mirror CPU inputs, cpu_stall=0. cpu_rdata=dm_rdata always. Zero added latency for CPU.
//  - wait_cnt: cleared on gnt or state!=BURST; else +1 per cycle, saturating at STARVE_LIMIT.
//    Guarantees CPU stall never exceeds 1 consecutive cycle.
//  - On gnt edge: cur_addr+=4 (wraps mod 2^32), beat_cnt-=1; write: dma_wack=1 same cycle;
//    read: next cycle dma_rvalid=1, dma_rdata=dm_rdata captured at gnt edge.
//  - dma_start during BURST/DONE ignored. dma_busy=1 in BURST and DONE.
//  - Last read beat's rvalid coincides with dma_done.
//  - Reset mid-burst aborts immediately: no done pulse, no pending rvalid.
// TESTING
//  1. CPU idle, dma_start we=0 addr=0x40 len=3 -> grants 3 consecutive cycles, addrs 0x40/44/48,
//     rvalid on cycles 2..4 with mem words, dma_done with last rvalid.
//  2. CPU storing every cycle, DMA write len=1 -> gnt on 5th BURST cycle (wait_cnt=4),
//     cpu_stall=1 that cycle only, dm_memwrite=2'b11, dma_wack=1.
//  3. CPU continuous, DMA len=3 -> forced beats every 5 cycles, no two adjacent stall cycles.
//  4. dma_len=0 -> 16 beats; addr 0xFFFF_FFF8 len=4 -> addresses wrap to 0x0, 0x4.
//  5. dma_start pulsed mid-burst -> ignored, beat count and addresses unchanged.
//  6. rst asserted mid-read-burst -> dma_busy, dma_rvalid drop immediately, dm codes 0; idle after release.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: the CPU MEM stage has priority, and a DMA burst engine takes
// free cycles. A starvation counter forces one DMA beat (stalling the CPU) after STARVE_LIMIT waits.
module dm_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_LEN      = 16,
    parameter logic [1:0]  DMA_WR_CODE  = 2'b11,
    parameter logic [2:0]  DMA_RD_CODE  = 3'b011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  cpu_memwrite,
    input  logic [2:0]  cpu_memread,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_start,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [4:0]  dma_len,
    input  logic [31:0] dma_wdata,
    output logic        dma_wack,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        dma_busy,
    output logic        dma_done,
    output logic [1:0]  dm_memwrite,
    output logic [2:0]  dm_memread,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam int unsigned WaitW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned LenW  = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

    state_e            state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [LenW-1:0]   beat_q, beat_d;
    logic [LenW-1:0]   len_eff;
    logic [31:0]       addr_q, addr_d;
    logic              we_q, we_d;
    logic              rvalid_q;
    logic [31:0]       rdata_q;
    logic              cpu_act;
    logic              gnt;
    logic              last_beat;

    assign cpu_act   = (|cpu_memwrite) | (|cpu_memread);
    assign gnt       = (state_q == StBurst) && (!cpu_act || (32'(wait_q) >= STARVE_LIMIT));
    assign last_beat = gnt && (beat_q == LenW'(1));

    // Zero or oversize lengths run a full-size burst.
    always_comb begin
        len_eff = LenW'(dma_len);
        if (dma_len == 5'd0 || 32'(dma_len) > MAX_LEN) begin
            len_eff = LenW'(MAX_LEN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (dma_start) state_d = StBurst;
            StBurst: if (last_beat) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dm_memwrite = cpu_memwrite;
        dm_memread  = cpu_memread;
        dm_addr     = cpu_addr;
        dm_wdata    = cpu_wdata;
        cpu_stall   = 1'b0;
        dma_wack    = 1'b0;
        if (gnt) begin
            dm_memwrite = we_q ? DMA_WR_CODE : 2'b00;
            dm_memread  = we_q ? 3'b000 : DMA_RD_CODE;
            dm_addr     = addr_q;
            dm_wdata    = dma_wdata;
            cpu_stall   = cpu_act;
            dma_wack    = we_q;
        end
        // No memory access of any kind while reset is held.
        if (rst) begin
            dm_memwrite = 2'b00;
            dm_memread  = 3'b000;
        end
    end

    assign cpu_rdata  = dm_rdata;
    assign dma_busy   = (state_q != StIdle);
    assign dma_done   = (state_q == StDone);
    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;

    always_comb begin
        addr_d = addr_q;
        beat_d = beat_q;
        we_d   = we_q;
        wait_d = wait_q;
        if (state_q == StIdle && dma_start) begin
            addr_d = dma_addr;
            beat_d = len_eff;
            we_d   = dma_we;
        end else if (gnt) begin
            addr_d = addr_q + 32'd4;
            beat_d = beat_q - LenW'(1);
        end
        if (state_q != StBurst || gnt) begin
            wait_d = '0;
        end else if (32'(wait_q) < STARVE_LIMIT) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            beat_q   <= '0;
            we_q     <= 1'b0;
            wait_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            we_q     <= we_d;
            wait_q   <= wait_d;
            rvalid_q <= gnt && !we_q;
            if (gnt && !we_q) begin
                rdata_q <= dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Randomized bench for dm_port_arbiter against a cycle-level behavioural model of the
// sharing rules: CPU priority, forced DMA beats after the starvation limit, burst bookkeeping.
module tb_dm_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cpu_memwrite;
    logic [2:0]  cpu_memread;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_start, dma_we;
    logic [31:0] dma_addr;
    logic [4:0]  dma_len;
    logic [31:0] dma_wdata;
    logic        dma_wack;
    logic [31:0] dma_rdata;
    logic        dma_rvalid, dma_busy, dma_done;
    logic [1:0]  dm_memwrite;
    logic [2:0]  dm_memread;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    assign dm_rdata = mem_word(dm_addr);

    dm_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_memwrite (cpu_memwrite),
        .cpu_memread  (cpu_memread),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .dma_start    (dma_start),
        .dma_we       (dma_we),
        .dma_addr     (dma_addr),
        .dma_len      (dma_len),
        .dma_wdata    (dma_wdata),
        .dma_wack     (dma_wack),
        .dma_rdata    (dma_rdata),
        .dma_rvalid   (dma_rvalid),
        .dma_busy     (dma_busy),
        .dma_done     (dma_done),
        .dm_memwrite  (dm_memwrite),
        .dm_memread   (dm_memread),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc, got, exp);
        end
    endtask

    // Model: phase 0 idle, 1 transferring, 2 completion cycle.
    int          m_phase, m_left, m_wait;
    logic [31:0] m_addr, m_rdata;
    bit          m_we, m_rv;

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_wait = 0;
        m_addr = '0; m_rdata = '0; m_we = 0; m_rv = 0;
    endtask

    int  act_pct [4] = '{0, 100, 50, 20};
    bit  force_rst;
    bit  prev_stall;
    bit  act, g;

    initial begin
        rst = 1'b1;
        cpu_memwrite = '0; cpu_memread = '0; cpu_addr = '0; cpu_wdata = '0;
        dma_start = 0; dma_we = 0; dma_addr = '0; dma_len = '0; dma_wdata = '0;
        model_reset();
        prev_stall = 0;
        #1;
        check("reset_busy",   32'(dma_busy),    32'd0);
        check("reset_rvalid", 32'(dma_rvalid),  32'd0);
        check("reset_done",   32'(dma_done),    32'd0);
        check("reset_rdata",  dma_rdata,        32'd0);
        check("reset_mw",     32'(dm_memwrite), 32'd0);
        check("reset_mr",     32'(dm_memread),  32'd0);

        for (int mode = 0; mode < 4; mode++) begin
            force_rst = (mode == 2);
            for (int i = 0; i < 700; i++) begin
                @(negedge clk);
                cyc++;
                // Inputs change here, away from the rising edge.
                rst = ($urandom_range(0, 149) == 0) ||
                      (force_rst && m_phase == 1 && !m_we && m_rv && $urandom_range(0, 3) == 0) ||
                      (mode == 0 && i < 2);
                cpu_memwrite = '0; cpu_memread = '0;
                if ($urandom_range(1, 100) <= act_pct[mode]) begin
                    if ($urandom_range(0, 1) == 1) cpu_memwrite = 2'($urandom_range(1, 3));
                    else                           cpu_memread  = 3'($urandom_range(1, 7));
                end
                cpu_addr  = $urandom();
                cpu_wdata = $urandom();
                dma_start = ($urandom_range(0, 3) == 0);
                dma_we    = $urandom_range(0, 1) == 1;
                dma_addr  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8
                                                        : {$urandom() & 32'hFFFF_FFFC};
                dma_len   = 5'($urandom_range(0, 31));
                dma_wdata = $urandom();
                #1;
                if (rst) model_reset();
                act = (cpu_memwrite != 0) || (cpu_memread != 0);
                g   = !rst && m_phase == 1 && (!act || m_wait >= LIMIT);

                check("busy",   32'(dma_busy),   32'(m_phase != 0));
                check("done",   32'(dma_done),   32'(m_phase == 2));
                check("rvalid", 32'(dma_rvalid), 32'(m_rv));
                check("rdata",  dma_rdata,       m_rdata);
                check("wack",   32'(dma_wack),   32'(g && m_we));
                check("stall",  32'(cpu_stall),  32'(g && act));
                if (rst) begin
                    check("rst_mw", 32'(dm_memwrite), 32'd0);
                    check("rst_mr", 32'(dm_memread),  32'd0);
                end else begin
                    check("dm_mw",     32'(dm_memwrite), g ? (m_we ? 32'd3 : 32'd0)
                                                           : 32'(cpu_memwrite));
                    check("dm_mr",     32'(dm_memread),  g ? (m_we ? 32'd0 : 32'd3)
                                                           : 32'(cpu_memread));
                    check("dm_addr",   dm_addr,   g ? m_addr : cpu_addr);
                    check("dm_wdata",  dm_wdata,  g ? dma_wdata : cpu_wdata);
                    check("cpu_rdata", cpu_rdata, mem_word(g ? m_addr : cpu_addr));
                end
                if (cpu_stall && prev_stall) check("stall_run", 32'd2, 32'd1);
                prev_stall = cpu_stall;

                // Advance the model to the state after the coming rising edge.
                if (!rst) begin
                    m_rv = g && !m_we;
                    if (m_rv) m_rdata = mem_word(m_addr);
                    if (m_phase != 1 || g) m_wait = 0;
                    else if (m_wait < LIMIT) m_wait++;
                    case (m_phase)
                        0: if (dma_start) begin
                            m_phase = 1;
                            m_addr  = dma_addr;
                            m_we    = dma_we;
                            m_left  = (dma_len == 0 || dma_len > 16) ? 16 : int'(dma_len);
                        end
                        1: if (g) begin
                            m_addr = m_addr + 32'd4;
                            m_left--;
                            if (m_left == 0) m_phase = 2;
                        end
                        default: m_phase = 0;
                    endcase
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
